request_encoder: RTL and testbench



---
 rtl/request_encoder.sv | 108 ++++++++++
 tb/tb_request_encoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/request_encoder.sv
// request_encoder: sequential 4-to-2 encoder feeding a 2-to-4 decoder.
// One-cycle request strobes are queued as pending bits. One index at a time
// is presented as {address1,address0} with enable high until ack.
module request_encoder #(
    parameter bit ROUND_ROBIN = 1'b0,
    parameter int GATE_DELAY  = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       ack,
    output logic       address0,
    output logic       address1,
    output logic       enable,
    output logic       dropped,
    output logic [3:0] pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [1:0] last_q, last_d;
    logic [3:0] pending_q, pending_d;
    logic       dropped_q, dropped_d;

    logic [3:0] req;
    logic [3:0] cand;
    logic [3:0] issued;
    logic [1:0] start;
    logic [1:0] sel;

    // The selector is behavioural and registered, so a gate-level delay has
    // nothing to annotate; the parameter is kept so existing overrides still bind.
    logic unused_gate_delay;
    assign unused_gate_delay = (GATE_DELAY != 0);

    // First set bit of c, scanning upward from start with wrap-around.
    function automatic logic [1:0] pick(input logic [3:0] c, input logic [1:0] from);
        logic [1:0] idx;
        logic       found;
        pick  = from;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = from + 2'(i);
            if (!found && c[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign req   = {in3, in2, in1, in0};
    assign cand  = pending_q | req;
    assign start = ROUND_ROBIN ? 2'(last_q + 2'd1) : 2'd0;
    assign sel   = pick(cand, start);

    // Next-state: load a new index when idle or on ack; queue all other requests.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        last_d    = last_q;
        issued    = '0;
        if ((state_q == IDLE) || ack) begin
            if (cand != '0) begin
                issued  = 4'b0001 << sel;
                addr_d  = sel;
                last_d  = sel;
                state_d = PRESENT;
            end else begin
                state_d = IDLE;
            end
        end
        // The issued bit is consumed by the load even when requested this edge.
        pending_d = cand & ~issued;
        dropped_d = |(req & pending_q & ~issued);
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            last_q    <= 2'd3;
            pending_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    assign address0 = addr_q[0];
    assign address1 = addr_q[1];
    assign enable   = (state_q == PRESENT);
    assign dropped  = dropped_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_request_encoder.sv
// Scoreboard bench for request_encoder: a fixed-priority and a round-robin
// instance share stimulus; a queue-based reference model predicts each cycle.
module tb_request_encoder;

    typedef struct packed {
        logic       en;
        logic [1:0] addr;
        logic [3:0] pend;
        logic       drop;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_vec = '0;
    logic       ack = 1'b0;

    logic       a0 [2];
    logic       a1 [2];
    logic       en [2];
    logic       drp [2];
    logic [3:0] pnd [2];

    int n_checks = 0;
    int n_pass = 0;
    bit done = 0;

    obs_t q0[$];
    obs_t q1[$];

    // Reference model state per instance (0 = fixed priority, 1 = round robin).
    int cur [2];
    int last_i [2];
    int addr_m [2];
    bit pend_m [2][4];

    always #5 clk = ~clk;

    request_encoder #(.ROUND_ROBIN(1'b0), .GATE_DELAY(50)) dut_fixed (
        .clk(clk), .reset_n(reset_n),
        .in0(in_vec[0]), .in1(in_vec[1]), .in2(in_vec[2]), .in3(in_vec[3]),
        .ack(ack), .address0(a0[0]), .address1(a1[0]), .enable(en[0]),
        .dropped(drp[0]), .pending(pnd[0])
    );

    request_encoder #(.ROUND_ROBIN(1'b1), .GATE_DELAY(50)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .in0(in_vec[0]), .in1(in_vec[1]), .in2(in_vec[2]), .in3(in_vec[3]),
        .ack(ack), .address0(a0[1]), .address1(a1[1]), .enable(en[1]),
        .dropped(drp[1]), .pending(pnd[1])
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cur[i]    = -1;
            last_i[i] = 3;
            addr_m[i] = 0;
            for (int x = 0; x < 4; x++) pend_m[i][x] = 0;
        end
    endtask

    // Predict the outputs after the coming edge and queue them.
    task automatic model_step(input logic [3:0] r, input logic a);
        obs_t o;
        for (int i = 0; i < 2; i++) begin
            int issue = -1;
            bit drop = 0;
            if (cur[i] < 0 || a) begin
                for (int k = 0; k < 4; k++) begin
                    int idx = (i == 1) ? (last_i[i] + 1 + k) % 4 : k;
                    if (issue < 0 && (pend_m[i][idx] || r[idx])) issue = idx;
                end
                cur[i] = issue;
                if (issue >= 0) begin
                    last_i[i] = issue;
                    addr_m[i] = issue;
                end
            end
            for (int x = 0; x < 4; x++) begin
                if (r[x] && pend_m[i][x] && x != issue) drop = 1;
                pend_m[i][x] = (pend_m[i][x] || r[x]) && (x != issue);
            end
            o.en   = (cur[i] >= 0);
            o.addr = 2'(addr_m[i]);
            o.drop = drop;
            for (int x = 0; x < 4; x++) o.pend[x] = pend_m[i][x];
            if (i == 0) q0.push_back(o);
            else q1.push_back(o);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic a);
        in_vec = r;
        ack    = a;
        model_step(r, a);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_enable"}, int'(en[i]), 0);
            check({tag, "_address"}, int'({a1[i], a0[i]}), 0);
            check({tag, "_pending"}, int'(pnd[i]), 0);
            check({tag, "_dropped"}, int'(drp[i]), 0);
        end
    endtask

    // Asynchronous reset asserted between edges, released one cycle later.
    task automatic do_reset(input string tag);
        in_vec  = '0;
        ack     = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic compare(input int i, input obs_t e);
        string s = (i == 0) ? "fixed" : "rr";
        check({s, "_enable"}, int'(en[i]), int'(e.en));
        if (e.en) check({s, "_address"}, int'({a1[i], a0[i]}), int'(e.addr));
        check({s, "_pending"}, int'(pnd[i]), int'(e.pend));
        check({s, "_dropped"}, int'(drp[i]), int'(e.drop));
    endtask

    // Monitor: pops one expected record per instance each cycle after the edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare(0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare(1, e);
            end
        end
    end

    // Directed sequence: {ack, in3..in0} per cycle.
    logic [4:0] dir [22] = '{
        5'h04, 5'h00, 5'h10, 5'h00,
        5'h0F, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00,
        5'h01, 5'h02, 5'h02, 5'h10, 5'h10,
        5'h04, 5'h14, 5'h10,
        5'h19, 5'h19, 5'h19, 5'h19
    };

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("init_reset");
        reset_n = 1'b1;

        // Present index 0, queue 1 and 3, then reset mid-presentation.
        step(4'h1, 1'b0);
        step(4'hA, 1'b0);
        check("pre_reset_pending", int'(pnd[0]), 10);
        do_reset("mid_reset");

        for (int n = 0; n < 22; n++) begin
            logic [4:0] d;
            d = dir[n];
            step(d[3:0], d[4]);
        end
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] r;
            r = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 96) == 0) do_reset("rand_reset");
            step(r, ($urandom_range(0, 2) != 0));
        end

        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        done = 1;
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
